periph_bus: RTL and testbench

PERIPH_BUS -- requirements
Module: periph_bus

---
 rtl/periph_bus.sv | 181 ++++++++++++++++++
 tb/tb_periph_bus.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// periph_bus: single-master to NUM_SLAVES peripheral bus bridge.
//
// A master request is accepted only in IDLE. Its address is decoded against
// per-slot base/size windows (lowest slot wins on overlap). A hit forwards the
// latched request to the selected slot and waits for that slot's s_ready, or
// for TIMEOUT wait cycles. A miss or a timeout completes with m_err=1. Every
// accepted request ends with exactly one RESP cycle carrying m_ready=1.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   m_valid/m_addr/m_wdata/m_store_type   master request (zero store type = load)
//   m_ready/m_rdata/m_err                 one-cycle completion, data, error
//   s_valid                               one-hot request to the selected slot
//   s_addr/s_wdata/s_store_type           latched request, shared by all slots
//   s_ready/s_rdata                       per-slot completion and read data
//   err_count                             saturating count of error responses
module periph_bus #(
  parameter int                          NUM_SLAVES = 4,
  parameter int                          DATA_W     = 64,
  parameter int                          ADDR_W     = 64,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_ADDRS = '0,
  parameter logic [NUM_SLAVES*8-1:0]      SIZE_LOG2  = '0,
  parameter int                          TIMEOUT    = 16,
  parameter type                         mem_store_type_t = logic [2:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_valid,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  mem_store_type_t              m_store_type,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output mem_store_type_t              s_store_type,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [7:0]                   err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  mem_store_type_t       store_q, store_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic                  m_ready_q, m_ready_d;
  logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
  logic                  m_err_q, m_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;

  // Address decode. Scanning from the top slot down lets the lowest
  // matching slot overwrite any higher match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((m_addr >> SIZE_LOG2[i*8 +: 8]) ==
          (BASE_ADDRS[i*ADDR_W +: ADDR_W] >> SIZE_LOG2[i*8 +: 8])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    s_valid_d = s_valid_q;
    // Response outputs are single-cycle: zero unless entering RESP.
    m_ready_d = 1'b0;
    m_rdata_d = '0;
    m_err_d   = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (m_valid) begin
          addr_d  = m_addr;
          wdata_d = m_wdata;
          store_d = m_store_type;
          sel_d   = hit_idx;
          cnt_d   = '0;
          if (hit) begin
            state_d   = WAIT;
            s_valid_d = NUM_SLAVES'(1) << hit_idx;
          end else begin
            state_d   = RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end

      WAIT: begin
        // A ready arriving on the timeout cycle is checked first, so it wins.
        if (s_ready[sel_q]) begin
          state_d   = RESP;
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_rdata_d = (store_q == '0) ? s_rdata[int'(sel_q)*DATA_W +: DATA_W] : '0;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d   = RESP;
          s_valid_d = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        // Never accepts here; a held m_valid is taken in the next IDLE cycle.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        s_valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      store_q   <= '0;
      cnt_q     <= '0;
      s_valid_q <= '0;
      m_ready_q <= 1'b0;
      m_rdata_q <= '0;
      m_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      store_q   <= store_d;
      cnt_q     <= cnt_d;
      s_valid_q <= s_valid_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
      m_err_q   <= m_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_ready      = m_ready_q;
  assign m_rdata      = m_rdata_q;
  assign m_err        = m_err_q;
  assign s_valid      = s_valid_q;
  assign s_addr       = addr_q;
  assign s_wdata      = wdata_q;
  assign s_store_type = store_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus. Instance a: slots at 0x1000/0x2000/0x3000/
// 0x4000, 4 KiB each. Instance b: slots 0 and 2 both cover 0x2010.
module tb_periph_bus;

  localparam int NS = 4;
  localparam int DW = 64;
  localparam int AW = 64;

  logic clk;
  logic reset;

  // instance a
  logic            a_m_valid;
  logic [AW-1:0]   a_m_addr;
  logic [DW-1:0]   a_m_wdata;
  logic [2:0]      a_m_store_type;
  logic            a_m_ready;
  logic [DW-1:0]   a_m_rdata;
  logic            a_m_err;
  logic [NS-1:0]   a_s_valid;
  logic [AW-1:0]   a_s_addr;
  logic [DW-1:0]   a_s_wdata;
  logic [2:0]      a_s_store_type;
  logic [NS-1:0]   a_s_ready;
  logic [NS*DW-1:0] a_s_rdata;
  logic [7:0]      a_err_count;

  // instance b
  logic            b_m_valid;
  logic [AW-1:0]   b_m_addr;
  logic [DW-1:0]   b_m_wdata;
  logic [2:0]      b_m_store_type;
  logic            b_m_ready;
  logic [DW-1:0]   b_m_rdata;
  logic            b_m_err;
  logic [NS-1:0]   b_s_valid;
  logic [AW-1:0]   b_s_addr;
  logic [DW-1:0]   b_s_wdata;
  logic [2:0]      b_s_store_type;
  logic [NS-1:0]   b_s_ready;
  logic [NS*DW-1:0] b_s_rdata;
  logic [7:0]      b_err_count;

  int n_total = 0;
  int n_bad   = 0;

  periph_bus #(
    .NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDRS({64'h4000, 64'h3000, 64'h2000, 64'h1000}),
    .SIZE_LOG2({8'd12, 8'd12, 8'd12, 8'd12}),
    .TIMEOUT(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .m_valid(a_m_valid), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_store_type(a_m_store_type), .m_ready(a_m_ready), .m_rdata(a_m_rdata),
    .m_err(a_m_err), .s_valid(a_s_valid), .s_addr(a_s_addr),
    .s_wdata(a_s_wdata), .s_store_type(a_s_store_type), .s_ready(a_s_ready),
    .s_rdata(a_s_rdata), .err_count(a_err_count)
  );

  periph_bus #(
    .NUM_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW),
    .BASE_ADDRS({64'hA000, 64'h2000, 64'h8000, 64'h2000}),
    .SIZE_LOG2({8'd12, 8'd8, 8'd12, 8'd12}),
    .TIMEOUT(16)
  ) dut_b (
    .clk(clk), .reset(reset),
    .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_store_type(b_m_store_type), .m_ready(b_m_ready), .m_rdata(b_m_rdata),
    .m_err(b_m_err), .s_valid(b_s_valid), .s_addr(b_s_addr),
    .s_wdata(b_s_wdata), .s_store_type(b_s_store_type), .s_ready(b_s_ready),
    .s_rdata(b_s_rdata), .err_count(b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int sv_cnt;

    reset = 1'b1;
    a_m_valid = 1'b0; a_m_addr = '0; a_m_wdata = '0; a_m_store_type = '0;
    a_s_ready = '0;   a_s_rdata = '0;
    b_m_valid = 1'b0; b_m_addr = '0; b_m_wdata = '0; b_m_store_type = '0;
    b_s_ready = '0;   b_s_rdata = '0;

    tick();
    tick();
    chk("rst_m_ready", 64'(a_m_ready), 64'd0);
    chk("rst_s_valid", 64'(a_s_valid), 64'd0);
    chk("rst_err_count", 64'(a_err_count), 64'd0);
    chk("rst_m_rdata", a_m_rdata, 64'd0);
    reset = 1'b0;
    tick();

    // Load hit on slot 1; s_ready held high already in IDLE must be ignored there.
    a_m_valid = 1'b1; a_m_addr = 64'h2010; a_m_store_type = 3'd0;
    a_s_rdata[1*DW +: DW] = 64'hDEAD;
    a_s_ready = 4'b0010;
    tick();
    chk("ld_s_valid", 64'(a_s_valid), 64'b0010);
    chk("ld_s_addr", a_s_addr, 64'h2010);
    chk("ld_no_early_ready", 64'(a_m_ready), 64'd0);
    a_m_valid = 1'b0;
    tick();
    chk("ld_m_ready", 64'(a_m_ready), 64'd1);
    chk("ld_m_rdata", a_m_rdata, 64'hDEAD);
    chk("ld_m_err", 64'(a_m_err), 64'd0);
    chk("ld_s_valid_drop", 64'(a_s_valid), 64'd0);
    a_s_ready = '0;
    tick();
    chk("ld_ready_pulse", 64'(a_m_ready), 64'd0);
    chk("ld_rdata_idle", a_m_rdata, 64'd0);

    // Miss.
    a_m_valid = 1'b1; a_m_addr = 64'h9000;
    tick();
    chk("miss_m_ready", 64'(a_m_ready), 64'd1);
    chk("miss_m_err", 64'(a_m_err), 64'd1);
    chk("miss_m_rdata", a_m_rdata, 64'd0);
    chk("miss_s_valid", 64'(a_s_valid), 64'd0);
    chk("miss_err_count", 64'(a_err_count), 64'd1);
    a_m_valid = 1'b0;
    tick();
    chk("miss_err_idle", 64'(a_m_err), 64'd0);

    // Timeout on slot 2; other slots' ready and address changes are ignored.
    a_m_valid = 1'b1; a_m_addr = 64'h3004;
    a_s_rdata[2*DW +: DW] = 64'h5555;
    tick();
    a_m_valid = 1'b0; a_m_addr = 64'h2000;
    a_s_ready = 4'b1011;
    cyc = 0; sv_cnt = 0;
    while (a_m_ready == 1'b0 && cyc < 40) begin
      if (a_s_valid == 4'b0100) sv_cnt++;
      tick();
      cyc++;
    end
    chk("to_s_valid_cycles", 64'(sv_cnt), 64'd16);
    chk("to_latency", 64'(cyc + 1), 64'd17);
    chk("to_m_err", 64'(a_m_err), 64'd1);
    chk("to_m_rdata", a_m_rdata, 64'd0);
    chk("to_s_addr_held", a_s_addr, 64'h3004);
    chk("to_err_count", 64'(a_err_count), 64'd2);
    a_s_ready = '0;
    tick();

    // Ready on the 16th wait cycle beats the timeout.
    a_m_valid = 1'b1; a_m_addr = 64'h3008;
    a_s_rdata[2*DW +: DW] = 64'h1234;
    tick();
    a_m_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("race_s_valid_c16", 64'(a_s_valid), 64'b0100);
    a_s_ready = 4'b0100;
    tick();
    chk("race_m_ready", 64'(a_m_ready), 64'd1);
    chk("race_m_err", 64'(a_m_err), 64'd0);
    chk("race_m_rdata", a_m_rdata, 64'h1234);
    chk("race_err_count", 64'(a_err_count), 64'd2);
    a_s_ready = '0;
    tick();

    // Back-to-back: store to slot 0 then load from slot 1 with m_valid held.
    a_s_rdata[0*DW +: DW] = 64'h1111;
    a_s_rdata[1*DW +: DW] = 64'h2222;
    a_s_ready = 4'b0011;
    a_m_valid = 1'b1; a_m_addr = 64'h1008; a_m_wdata = 64'hCAFE; a_m_store_type = 3'd3;
    tick();
    chk("b2b_st_s_valid", 64'(a_s_valid), 64'b0001);
    chk("b2b_st_wdata", a_s_wdata, 64'hCAFE);
    chk("b2b_st_type", 64'(a_s_store_type), 64'd3);
    a_m_addr = 64'h2020; a_m_store_type = 3'd0;
    tick();
    chk("b2b_st_ready", 64'(a_m_ready), 64'd1);
    chk("b2b_st_rdata", a_m_rdata, 64'd0);
    chk("b2b_st_err", 64'(a_m_err), 64'd0);
    tick();
    chk("b2b_gap_ready", 64'(a_m_ready), 64'd0);
    chk("b2b_gap_s_valid", 64'(a_s_valid), 64'd0);
    tick();
    chk("b2b_ld_s_valid", 64'(a_s_valid), 64'b0010);
    chk("b2b_ld_s_addr", a_s_addr, 64'h2020);
    a_m_valid = 1'b0;
    tick();
    chk("b2b_ld_ready", 64'(a_m_ready), 64'd1);
    chk("b2b_ld_rdata", a_m_rdata, 64'h2222);
    a_s_ready = '0;
    tick();
    chk("b2b_end_ready", 64'(a_m_ready), 64'd0);

    // Reset in WAIT.
    a_m_valid = 1'b1; a_m_addr = 64'h2010;
    tick();
    chk("rw_s_valid", 64'(a_s_valid), 64'b0010);
    a_m_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rw_s_valid_async", 64'(a_s_valid), 64'd0);
    chk("rw_err_count", 64'(a_err_count), 64'd0);
    tick();
    reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (a_m_ready) cyc++;
      tick();
    end
    chk("rw_no_m_ready", 64'(cyc), 64'd0);
    a_m_valid = 1'b1; a_m_addr = 64'h2010; a_s_ready = 4'b0010;
    a_s_rdata[1*DW +: DW] = 64'hDEAD;
    tick();
    chk("rw_new_s_valid", 64'(a_s_valid), 64'b0010);
    a_m_valid = 1'b0;
    tick();
    chk("rw_new_m_ready", 64'(a_m_ready), 64'd1);
    chk("rw_new_m_rdata", a_m_rdata, 64'hDEAD);
    a_s_ready = '0;
    tick();

    // Overlap on instance b: slot 0 wins, slot 2's ready is ignored.
    b_s_rdata[0*DW +: DW] = 64'hAAAA;
    b_s_rdata[2*DW +: DW] = 64'hBBBB;
    b_m_valid = 1'b1; b_m_addr = 64'h2010;
    tick();
    chk("ov_s_valid", 64'(b_s_valid), 64'b0001);
    b_m_valid = 1'b0;
    b_s_ready = 4'b0100;
    tick();
    chk("ov_ignored_ready", 64'(b_m_ready), 64'd0);
    chk("ov_s_valid_held", 64'(b_s_valid), 64'b0001);
    b_s_ready = 4'b0001;
    tick();
    chk("ov_m_ready", 64'(b_m_ready), 64'd1);
    chk("ov_m_rdata", b_m_rdata, 64'hAAAA);
    b_s_ready = '0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
